// File: rtl/note_seq_pkg.sv
// Shared types and defaults for the note step sequencer.
package note_seq_pkg;

   localparam int unsigned NOTE_W_DEF = 7;
   localparam int unsigned DUR_W_DEF  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      NOTE  = 2'd2,
      GAP   = 2'd3
   } state_t;

   typedef struct packed {
      logic [DUR_W_DEF-1:0]  dur;
      logic [NOTE_W_DEF-1:0] note;
   } entry_t;

   // A zero duration terminates the pattern.
   localparam logic [DUR_W_DEF-1:0] END_MARKER = '0;

endpackage

// File: rtl/seq_pattern_ram.sv
// Pattern storage: register array cleared on reset, synchronous write,
// combinational read (a same-cycle write is seen only on the next cycle).
module seq_pattern_ram #(
   parameter  int unsigned DEPTH = 32,
   parameter  int unsigned W     = 11,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem <= '{default: '0};
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/note_step_sequencer.sv
// Steps through a pattern of {duration, note} entries on tempo ticks,
// producing a gated note, a new-note strobe and busy/done status.
module note_step_sequencer
   import note_seq_pkg::*;
#(
   parameter  int unsigned DEPTH     = 32,
   parameter  int unsigned NOTE_W    = NOTE_W_DEF,
   parameter  int unsigned DUR_W     = DUR_W_DEF,
   parameter  int unsigned GAP_TICKS = 1,
   localparam int unsigned AW        = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   tick,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   loop,
   input  logic                   wr_en,
   input  logic [AW-1:0]          wr_addr,
   input  logic [DUR_W+NOTE_W-1:0] wr_data,
   output logic [NOTE_W-1:0]      note,
   output logic                   gate,
   output logic                   note_stb,
   output logic [AW-1:0]          step,
   output logic                   busy,
   output logic                   done
);

   logic [DUR_W+NOTE_W-1:0] rd_data;
   logic [DUR_W-1:0]        rd_dur;
   logic [NOTE_W-1:0]       rd_note;

   state_t              state_q, state_d;
   logic [AW-1:0]       step_q, step_d;
   logic [NOTE_W-1:0]   note_q, note_d;
   logic                gate_q, gate_d;
   logic                stb_q, stb_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
   logic [DUR_W-1:0]    gap_cnt_q, gap_cnt_d;
   logic                advance;

   seq_pattern_ram #(
      .DEPTH (DEPTH),
      .W     (DUR_W + NOTE_W)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (step_q),
      .rd_data (rd_data)
   );

   assign rd_dur  = rd_data[NOTE_W +: DUR_W];
   assign rd_note = rd_data[NOTE_W-1:0];

   // State and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         step_q    <= '0;
         note_q    <= '0;
         gate_q    <= 1'b0;
         stb_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dur_cnt_q <= '0;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         note_q    <= note_d;
         gate_q    <= gate_d;
         stb_q     <= stb_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dur_cnt_q <= dur_cnt_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

   // Next-state and next-output logic; stop overrides everything.
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      note_d    = note_q;
      gate_d    = gate_q;
      stb_d     = 1'b0;
      done_d    = 1'b0;
      dur_cnt_d = dur_cnt_q;
      gap_cnt_d = gap_cnt_q;
      advance   = 1'b0;

      if (stop) begin
         state_d = IDLE;
         gate_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  step_d  = '0;
                  state_d = FETCH;
               end
            end
            FETCH: begin
               if (rd_dur == DUR_W'(END_MARKER)) begin
                  if (loop && (step_q != '0)) begin
                     step_d = '0;
                  end else begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  note_d    = rd_note;
                  dur_cnt_d = rd_dur;
                  gate_d    = 1'b1;
                  stb_d     = 1'b1;
                  state_d   = NOTE;
               end
            end
            NOTE: begin
               if (tick) begin
                  dur_cnt_d = dur_cnt_q - DUR_W'(1);
                  if (dur_cnt_q == DUR_W'(1)) begin
                     gate_d = 1'b0;
                     if (GAP_TICKS > 0) begin
                        gap_cnt_d = DUR_W'(GAP_TICKS);
                        state_d   = GAP;
                     end else begin
                        advance = 1'b1;
                     end
                  end
               end
            end
            GAP: begin
               if (tick) begin
                  gap_cnt_d = gap_cnt_q - DUR_W'(1);
                  if (gap_cnt_q == DUR_W'(1)) begin
                     advance = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Running off the last entry counts as reaching the end marker.
      if (advance) begin
         if (step_q == AW'(DEPTH - 1)) begin
            if (loop) begin
               step_d  = '0;
               state_d = FETCH;
            end else begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end else begin
            step_d  = step_q + AW'(1);
            state_d = FETCH;
         end
      end

      busy_d = (state_d != IDLE);
   end

   assign note     = note_q;
   assign gate     = gate_q;
   assign note_stb = stb_q;
   assign step     = step_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_note_step_sequencer.sv
// Scoreboard bench: a pattern-walking reference model queues expected
// note/done events; a negedge monitor pops and compares them.
module tb_note_step_sequencer;
   import note_seq_pkg::*;

   localparam int DEPTH  = 32;
   localparam int AW     = 5;
   localparam int GAP    = 1;
   localparam int TICK_P = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          tick = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          loop = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [10:0]   wr_data = '0;
   logic [6:0]    note;
   logic          gate, note_stb, busy, done;
   logic [AW-1:0] step;

   note_step_sequencer #(
      .DEPTH(DEPTH), .NOTE_W(7), .DUR_W(4), .GAP_TICKS(GAP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop),
      .loop(loop), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .note(note), .gate(gate), .note_stb(note_stb), .step(step),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;   // 1 = note start, 2 = done
      int note;
      int step;
      int dur;
   } ev_t;

   ev_t q[$];
   int  pat_dur [DEPTH];
   int  pat_note[DEPTH];
   int  model_note = 0;
   int  last_step  = 0;
   int  total = 0, bad = 0;
   int  stb_seen = 0;
   bit  tick_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp_v);
      total++;
      if (act != exp_v) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
      end
   endtask

   // Tempo strobe: one cycle every TICK_P clocks.
   initial begin
      int c;
      c = 0;
      forever begin
         @(posedge clk); #1;
         c++;
         tick = tick_en && (c % TICK_P == 0);
      end
   end

   // Monitor: compare each presented event and the ticks each gate spans.
   int cnt = 0, exp_dur = 0;
   bit prev_gate = 1'b0, prev_stop = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_gate = 1'b0;
         prev_stop = 1'b0;
         cnt       = 0;
      end else begin
         if (note_stb || done) begin
            if (q.size() == 0) begin
               chk("extra_event", int'(note_stb) + 2 * int'(done), 0);
            end else begin
               ev_t e;
               e = q.pop_front();
               chk("ev_kind", done ? 2 : 1, e.kind);
               chk("ev_note", int'(note), e.note);
               chk("ev_step", int'(step), e.step);
               if (e.kind == 1) begin
                  chk("stb_gate", int'(gate), 1);
                  exp_dur = e.dur;
                  cnt     = 0;
               end else begin
                  chk("done_busy", int'(busy), 0);
                  chk("done_gate", int'(gate), 0);
               end
            end
         end
         if (note_stb) stb_seen++;
         if (gate && tick) cnt++;
         if (prev_gate && !gate && !prev_stop) chk("gate_ticks", cnt, exp_dur);
         prev_gate = gate;
         prev_stop = stop;
      end
   end

   // Reference model: walk the pattern and queue what playback should show.
   task automatic gen(input bit lp, input int max_stb, output int n);
      int s;
      s = 0;
      n = 0;
      for (int it = 0; it < 4000; it++) begin
         if (pat_dur[s] == 0) begin
            if (lp && s != 0) begin
               s = 0;
               continue;
            end
            q.push_back('{2, model_note, s, 0});
            return;
         end
         if (n >= max_stb) return;
         q.push_back('{1, pat_note[s], s, pat_dur[s]});
         model_note = pat_note[s];
         last_step  = s;
         n++;
         if (s == DEPTH - 1) begin
            if (lp) s = 0;
            else begin
               q.push_back('{2, model_note, s, 0});
               return;
            end
         end else begin
            s++;
         end
      end
   endtask

   task automatic write_entry(input int a, input int d, input int n);
      entry_t e;
      e.dur  = 4'(d);
      e.note = 7'(n);
      @(posedge clk); #1;
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = e;
      pat_dur[a]  = d;
      pat_note[a] = n;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run(input bit lp, input int max_stb, input bit do_stop);
      int n, target, held;
      loop = lp;
      gen(lp, max_stb, n);
      target = stb_seen + n;
      held   = last_step;
      pulse_start();
      if (do_stop) begin
         for (int t = 0; t < 20000; t++) begin
            if (stb_seen >= target) break;
            @(posedge clk); #1;
         end
         chk("stop_reach", stb_seen, target);
         @(posedge clk); #1;
         stop = 1'b1;
         @(posedge clk); #1;
         stop = 1'b0;
         @(negedge clk);
         chk("stop_gate", int'(gate), 0);
         chk("stop_busy", int'(busy), 0);
         chk("stop_step", int'(step), held);
         repeat (3 * TICK_P) @(negedge clk);
         chk("stop_queue", q.size(), 0);
         chk("stop_idle", int'(busy), 0);
         q.delete();
      end else begin
         for (int t = 0; t < 20000; t++) begin
            @(negedge clk);
            if (!busy && q.size() == 0) break;
         end
         chk("run_queue", q.size(), 0);
         chk("run_busy", int'(busy), 0);
      end
   endtask

   initial begin
      int n, len;
      for (int i = 0; i < DEPTH; i++) begin
         pat_dur[i]  = 0;
         pat_note[i] = 0;
      end
      tick_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_note", int'(note), 0);
      chk("rst_gate", int'(gate), 0);
      chk("rst_stb", int'(note_stb), 0);
      chk("rst_step", int'(step), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Empty pattern straight after reset.
      run(1'b0, 1000, 1'b0);

      // Two-note pattern, single pass then three looping passes.
      write_entry(0, 2, 60);
      write_entry(1, 1, 64);
      write_entry(2, 0, 0);
      run(1'b0, 1000, 1'b0);
      run(1'b1, 6, 1'b1);

      // Four notes, stop while step 2 sounds, then replay from step 0.
      for (int i = 0; i < 4; i++) write_entry(i, 2 + (i % 2), 48 + 3 * i);
      write_entry(4, 0, 0);
      run(1'b0, 3, 1'b1);
      run(1'b0, 1000, 1'b0);

      // Every entry used: the pass ends by wrapping past the last step.
      for (int i = 0; i < DEPTH; i++) write_entry(i, 1, int'($urandom_range(0, 127)));
      run(1'b0, 1000, 1'b0);

      // Random patterns, random loop mode.
      for (int r = 0; r < 4; r++) begin
         len = int'($urandom_range(1, 12));
         for (int i = 0; i < len; i++)
            write_entry(i, int'($urandom_range(1, 3)), int'($urandom_range(0, 127)));
         write_entry(len, 0, 0);
         if ($urandom_range(0, 1) == 1) run(1'b1, len + int'($urandom_range(1, 4)), 1'b1);
         else run(1'b0, 1000, 1'b0);
      end

      // Asynchronous reset while a note is sounding.
      loop = 1'b0;
      gen(1'b0, 1, n);
      pulse_start();
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (gate) break;
      end
      chk("pre_rst_gate", int'(gate), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_gate", int'(gate), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_note", int'(note), 0);
      chk("arst_step", int'(step), 0);
      q.delete();
      model_note = 0;
      for (int i = 0; i < DEPTH; i++) begin
         pat_dur[i]  = 0;
         pat_note[i] = 0;
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run(1'b0, 1000, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
